exe_muldiv_unit: RTL
====================

Name: exe_muldiv_unit

Overview:
- Execute-stage iterative multiply/divide unit, fed directly from the ID/EX pipeline register outputs (operands busA/busB and decoded op).
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- Exposes a busy flag so the hazard unit stalls ID/EX while an operation runs.
- Radix-2, one bit per cycle, with a final sign-fix cycle.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits, product is 2*WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request valid this cycle (EXE stage holds a muldiv/MT op)
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op
src_a  input  WIDTH  rs operand (dividend / multiplicand / MT source)
src_b  input  WIDTH  rt operand (divisor / multiplier)
flush  input  1  abort in-flight operation (branch/exception kill)
busy  output  1  operation in flight; hazard unit stalls on busy
done  output  1  one-cycle pulse: HI/LO updated by mul/div
div0  output  1  one-cycle pulse with done: divide by zero
hi  output  WIDTH  HI register (MFHI source)
lo  output  WIDTH  LO register (MFLO source)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE, hi=lo=0, busy=0, done=0, div0=0, counter=0.
- States: IDLE, MUL, DIV, FIX.
- busy is 1 in every state except IDLE. done and div0 are registered.
- Accept rule:
  - start is sampled only in IDLE with flush=0.
  - In MUL/DIV/FIX, start is ignored.
  - flush wins over start in the same cycle.
- MTHI/MTLO at accept edge E0: hi (or lo) <= src_a. The unit stays IDLE, no done, busy stays 0.
- MULT/MULTU accepted at E0:
  - Load |a| and |b| (signed op) or raw values (unsigned) into a 2*WIDTH multiplicand shift register and a WIDTH multiplier shift register.
  - Record result sign = a[31]^b[31] (signed op only). Clear the 2*WIDTH accumulator and counter. Go to MUL.
- MUL edges E1..E32:
  - If multiplier[0], accumulator += multiplicand.
  - Multiplicand <<1, multiplier >>1, counter+1.
  - When counter reaches WIDTH-1 on this edge, go to FIX.
- DIV/DIVU accepted at E0 with src_b==0: go to FIX with div0 flagged. At E1: hi/lo unchanged, done=1, div0=1, state IDLE.
- DIV/DIVU accepted at E0 with src_b!=0:
  - Load magnitudes. Record quotient sign = a[31]^b[31] and remainder sign = a[31] (signed only). Go to DIV.
- DIV edges E1..E32: restoring step — shift {rem,quo} left, trial subtract divisor, set quotient bit if non-negative. Same counter rule as MUL.
- FIX (edge E33):
  - Apply two's-complement negation per recorded signs.
  - Write hi (upper product / remainder) and lo (lower product / quotient).
  - State IDLE; done=1 for exactly one cycle.
- Normal latency: busy high for 33 cycles after E0; done high in the cycle after E33.
- Division overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (magnitude wraps naturally). No trap.
- flush in MUL/DIV/FIX: next edge returns to IDLE. hi/lo unchanged, no done pulse, busy=0 after that edge.
- Reset mid-operation: identical to the reset values above; any partial result is discarded.
- hi/lo change only at FIX, at MT accept, and at reset.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- Defined: in MUL, if the post-shift multiplier is zero, go to FIX on that edge. Example: b=3 gives FIX at E3, done after E3. DIV timing is unchanged.
- Undefined: MUL always runs the full WIDTH iterations.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Macro off: done exactly 34 cycles after start; busy high 33 cycles. Macro on: done 4 cycles after start.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at cycle 34; a start issued while busy has no effect.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> done=div0=1 at cycle 2, hi/lo keep previous values.
- MULT started; flush asserted at iteration 10 -> busy=0 next cycle, no done, hi/lo unchanged. Then MTHI src_a=0x1234 -> hi=0x1234 next cycle, lo untouched.
- rst asserted during DIV iteration 20 -> next cycle busy=0, hi=lo=0, done=0. A new MULT 6*7 afterwards -> lo=42, hi=0.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// Execute-stage radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Latency: MUL/DIV 33 cycles busy after accept (iterations plus a sign-fix cycle), done pulses the cycle after; MTHI/MTLO update in 1 cycle.
// Backpressure: busy stalls the ID/EX stage; start is ignored unless IDLE; flush aborts in-flight work.
// Optional: define MULDIV_EARLY_OUT_EN to end multiplication once the remaining multiplier bits are zero.
module exe_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  // MUL: shifting multiplicand. DIV: low half holds the divisor.
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  // MUL: shifting multiplier. DIV: dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  // MUL: product accumulator. DIV: low half holds the partial remainder.
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic                 neg_q,    neg_d;     // negate product / quotient at FIX
  logic                 rneg_q,   rneg_d;    // negate remainder at FIX
  logic                 is_div_q, is_div_d;
  logic                 dz_q,     dz_d;      // divide-by-zero pending
  logic [WIDTH-1:0]     hi_q,     hi_d;
  logic [WIDTH-1:0]     lo_q,     lo_d;
  logic                 done_q,   done_d;
  logic                 div0_q,   div0_d;

  // Operand magnitudes: only the signed ops (op[0]==0) take absolute values.
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & src_a[WIDTH-1];
  assign b_neg     = signed_op & src_b[WIDTH-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  // Restoring division step: shift {rem,quo} left by one and trial-subtract the divisor.
  // The partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic             unused_rem_msb;

  assign rem_sh         = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign q_bit          = (rem_sh >= {1'b0, mcand_q[WIDTH-1:0]});
  assign rem_sub        = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
  assign rem_next       = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign unused_rem_msb = rem_sub[WIDTH];

  // Sign-corrected results written at FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q  ? -acc_q            : acc_q;
  assign quo_fix  = neg_q  ? -mplier_q         : mplier_q;
  assign rem_fix  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  // Next-state and datapath: accept in IDLE, iterate in MUL/DIV, commit in FIX; flush overrides all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            OP_MULT, OP_MULTU: begin
              mcand_d  = {{WIDTH{1'b0}}, a_mag};
              mplier_d = b_mag;
              acc_d    = '0;
              cnt_d    = '0;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = 1'b0;
              is_div_d = 1'b0;
              dz_d     = 1'b0;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              is_div_d = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
              if (src_b == '0) begin
                dz_d    = 1'b1;
                state_d = S_FIX;
              end else begin
                dz_d     = 1'b0;
                mplier_d = a_mag;
                mcand_d  = {{WIDTH{1'b0}}, b_mag};
                neg_d    = a_neg ^ b_neg;
                rneg_d   = a_neg;
                state_d  = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        if ((mplier_q >> 1) == '0) state_d = S_FIX;
`endif
      end

      S_DIV: begin
        acc_d    = {{WIDTH{1'b0}}, rem_next};
        mplier_d = {mplier_q[WIDTH-2:0], q_bit};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          div0_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      div0_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
